// File: rtl/stream_accumulator.sv
// stream_accumulator: sums NUM_CH unsigned channels per accepted sample and
// accumulates those sample sums either without bound (WINDOW=0) or as a moving
// sum over the last WINDOW samples. out_sum wraps or clamps per SATURATE, and
// overflow is a sticky flag that records when the exact sum left the ACC_W range.
module stream_accumulator #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32,
  parameter int WINDOW   = 0,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     clear,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_valid,
  output logic                     overflow,
  output logic [15:0]              count
);

  // A sample sum of NUM_CH channels needs clog2(NUM_CH) extra bits so that it
  // never truncates.
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int SAMPLE_W = DATA_W + CH_W;

  // The history buffer always has at least one entry so that the unbounded
  // configuration still elaborates; it is simply never read there.
  localparam int BUF_N = (WINDOW > 0) ? WINDOW : 1;
  localparam int PTR_W = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  // A moving sum of BUF_N maximal samples fits in SAMPLE_W + clog2(BUF_N) bits.
  localparam int WIN_W = SAMPLE_W + ((BUF_N > 1) ? $clog2(BUF_N) : 0);

  // Working width for the exact sum: one bit wider than both the output range
  // and the moving-sum range, so the exact value and the range test are both
  // representable.
  localparam int EXT_W = ((ACC_W > WIN_W) ? ACC_W : WIN_W) + 1;

  localparam logic [EXT_W-1:0] ACC_MAX   = (EXT_W'(1) << ACC_W) - EXT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_N - 1);
  localparam logic [15:0]      WIN_CNT   = 16'(BUF_N);
  localparam logic [15:0]      CNT_MAX   = 16'hFFFF;
  localparam logic             WIN_MODE  = (WINDOW > 0) ? 1'b1 : 1'b0;
  localparam logic             SAT_MODE  = (SATURATE != 0) ? 1'b1 : 1'b0;

  // Registered state. In unbounded mode sum_r holds the (wrapped or clamped)
  // output value, which is all that later additions need; in window mode it
  // holds the exact moving sum so that clamping can release later.
  logic [EXT_W-1:0]    sum_r;
  logic [SAMPLE_W-1:0] buf_r [BUF_N];
  logic [PTR_W-1:0]    ptr_r;
  logic [ACC_W-1:0]    out_sum_r;
  logic                out_valid_r;
  logic                overflow_r;
  logic [15:0]         count_r;

  // Combinational next-state values.
  logic [SAMPLE_W-1:0] sample_s;
  logic [EXT_W-1:0]    base_s;
  logic [SAMPLE_W-1:0] evict_s;
  logic [EXT_W-1:0]    exact_s;
  logic                over_s;
  logic [ACC_W-1:0]    out_next_s;
  logic [EXT_W-1:0]    sum_next_s;
  logic [15:0]         count_next_s;
  logic                overflow_next_s;
  logic [PTR_W-1:0]    wr_ptr_s;
  logic [PTR_W-1:0]    ptr_next_s;

  // Add all channels of the current sample at full width.
  always_comb begin
    sample_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sample_s = sample_s + SAMPLE_W'(in_data[k*DATA_W +: DATA_W]);
    end
  end

  // Compute the exact next sum, its range check, and the wrapped/clamped output.
  always_comb begin
    // A clear together with a sample restarts from an empty history.
    if (clear) begin
      base_s   = '0;
      wr_ptr_s = '0;
    end else begin
      base_s   = sum_r;
      wr_ptr_s = ptr_r;
    end

    // Once the window is full the slot about to be overwritten is the oldest
    // sample, so it leaves the sum on the same edge the new one enters.
    if (WIN_MODE && !clear && (count_r == WIN_CNT)) begin
      evict_s = buf_r[ptr_r];
    end else begin
      evict_s = '0;
    end

    exact_s = base_s + EXT_W'(sample_s) - EXT_W'(evict_s);
    over_s  = (exact_s > ACC_MAX);

    if (SAT_MODE && over_s) begin
      out_next_s = ACC_W'(ACC_MAX);
    end else begin
      out_next_s = ACC_W'(exact_s);
    end

    if (WIN_MODE) begin
      sum_next_s = exact_s;
    end else begin
      sum_next_s = EXT_W'(out_next_s);
    end

    if (clear) begin
      overflow_next_s = over_s;
    end else begin
      overflow_next_s = overflow_r | over_s;
    end

    if (clear) begin
      count_next_s = 16'd1;
    end else if (WIN_MODE && (count_r == WIN_CNT)) begin
      count_next_s = count_r;
    end else if (count_r == CNT_MAX) begin
      count_next_s = count_r;
    end else begin
      count_next_s = count_r + 16'd1;
    end

    if (wr_ptr_s == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = wr_ptr_s + PTR_W'(1);
    end
  end

  // Sequential update: reset, bare clear, accepted sample, or hold.
  always_ff @(posedge clk) begin
    if (rst || (clear && !in_valid)) begin
      sum_r       <= '0;
      ptr_r       <= '0;
      out_sum_r   <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      count_r     <= 16'd0;
      for (int i = 0; i < BUF_N; i++) begin
        buf_r[i] <= '0;
      end
    end else if (in_valid) begin
      sum_r       <= sum_next_s;
      ptr_r       <= ptr_next_s;
      out_sum_r   <= out_next_s;
      out_valid_r <= 1'b1;
      overflow_r  <= overflow_next_s;
      count_r     <= count_next_s;
      if (clear) begin
        for (int i = 0; i < BUF_N; i++) begin
          buf_r[i] <= '0;
        end
      end
      buf_r[wr_ptr_s] <= sample_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_sum   = out_sum_r;
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign count     = count_r;

endmodule

// File: doc/stream_accumulator.md
STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

Interface
REQ-001 Parameter NUM_CH, default 2: number of input channels summed per accepted sample (>=1).
REQ-002 Parameter DATA_W, default 32: width of each channel, unsigned.
REQ-003 Parameter ACC_W, default 32: width of out_sum.
REQ-004 Parameter WINDOW, default 0: 0 = unbounded running sum; N>0 = moving sum over the last N accepted samples.
REQ-005 Parameter SATURATE, default 0: 0 = out_sum wraps modulo 2^ACC_W; 1 = out_sum clamps at 2^ACC_W-1.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  in_data is accepted on this rising edge.
REQ-009 in_data  input  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-010 clear  input  1  synchronous restart of the accumulation.
REQ-011 out_sum  output  ACC_W  registered running/moving sum.
REQ-012 out_valid  output  1  one-cycle pulse: out_sum was updated on the previous edge.
REQ-013 overflow  output  1  sticky: the exact sum has exceeded 2^ACC_W-1 since the last clear/reset.
REQ-014 count  output  16  accepted samples: in window mode saturates at WINDOW, otherwise saturates at 65535.

Function
REQ-015 Sample sum is the unsigned sum of all NUM_CH channels at width DATA_W+clog2(NUM_CH) and never truncates.
REQ-016 An edge with in_valid=1 updates out_sum, count and overflow on that edge; out_valid=1 during the following cycle only (latency 1).
REQ-017 An edge with in_valid=0 holds out_sum, count and overflow; out_valid=0 next cycle.
REQ-018 WINDOW=0: exact sum = previous exact sum + sample sum. Wrap mode: out_sum = exact mod 2^ACC_W. Saturate mode: out_sum = min(exact, 2^ACC_W-1) and stays clamped until clear.
REQ-019 WINDOW=N: block keeps the last N sample sums in a circular buffer. Exact sum adds the new sample and, once count==N, subtracts the evicted oldest sample on the same edge.
REQ-020 WINDOW=N: internal accumulator is wide enough for N maximal samples, so the exact moving sum never overflows. out_sum is that sum wrapped or clamped per SATURATE, and clamping releases when the moving sum falls back in range.
REQ-021 overflow is set on any edge where the exact sum exceeds 2^ACC_W-1, in either mode; only clear or rst clear it.
REQ-022 clear=1, in_valid=0: out_sum, count, overflow and all buffer entries go to 0; out_valid=0 next cycle.
REQ-023 clear=1, in_valid=1: prior state is discarded. The current sample becomes the first sample: out_sum = sample sum (wrapped/clamped), count=1, out_valid=1 next cycle, overflow reflects only this sample.
REQ-024 Circular buffer pointer wraps from N-1 to 0; no sample is lost or double-subtracted across the wrap.

Reset
REQ-025 rst=1 on an edge forces out_sum=0, out_valid=0, overflow=0, count=0, buffer pointer=0 and all buffer entries=0, regardless of in_valid and clear.
REQ-026 rst mid-stream discards all history; the first in_valid after rst deasserts produces out_sum = that sample sum.

Verification
REQ-027 Defaults: (1,2),(3,4),(5,9) on three consecutive valid edges -> out_sum 3, 10, 24; out_valid high for three cycles; count 3; overflow 0.
REQ-028 Defaults: (1,2), two idle cycles, then (3,4) -> out_sum holds 3 with out_valid=0 for two cycles, then 10 with out_valid pulse.
REQ-029 WINDOW=2: sample sums 3, 7, 14, 1 -> out_sum 3, 10, 21, 15; count 1, 2, 2, 2.
REQ-030 ACC_W=8, NUM_CH=1, DATA_W=8: inputs 200 then 100 -> SATURATE=0 gives 200 then 44 with overflow=1; SATURATE=1 gives 200 then 255 with overflow=1.
REQ-031 After sum 24, clear together with in_valid (5,9) -> out_sum 14, count 1, overflow 0. A clear alone -> out_sum 0, out_valid 0.
REQ-032 rst asserted for one edge after sum 10 -> all outputs 0 next cycle. A following (2,2) -> out_sum 4.
